// File: rtl/n_ripple_carry_adder_bist.sv
// Exhaustive on-board self-checker for the n-bit ripple-carry adder.
// Optional feature: define ADDER_BIST_STOP_ON_FAIL_EN to stop the sweep at the first mismatch.
module n_ripple_carry_adder_bist #(
  parameter int bits   = 2,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [2*bits:0]     dut_sw,
  input  logic [bits:0]       dut_ledr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*bits+1:0]   err_count,
  output logic [2*bits:0]     fail_vec
);

  localparam int VW = 2*bits + 1;
  localparam int EW = 2*bits + 2;
  localparam int WW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t          state;
  logic [VW-1:0]   vec;
  logic [WW-1:0]   settle_cnt;
  logic            first_fail;

  // Expected result at full bits+1 width so the carry is never truncated.
  logic [bits:0]   exp_sum;
  logic            mismatch;
  logic [EW-1:0]   err_next;

  always_comb begin
    exp_sum  = {1'b0, vec[2*bits-1:bits]} + {1'b0, vec[bits-1:0]}
             + {{bits{1'b0}}, vec[2*bits]};
    mismatch = (dut_ledr != exp_sum);
    err_next = err_count;
    if (mismatch && !(&err_count))
      err_next = err_count + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      first_fail <= 1'b0;
      dut_sw     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            vec        <= '0;
            settle_cnt <= '0;
            first_fail <= 1'b0;
            dut_sw     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
          end
        end
        APPLY: begin
          if (settle_cnt == SETTLE_LAST)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt + WW'(1);
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_fail) begin
            first_fail <= 1'b1;
            fail_vec   <= vec;
          end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
          if (mismatch || (&vec)) begin
`else
          if (&vec) begin
`endif
            // dut_sw is left on the final (or failing) vector for inspection.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= APPLY;
            vec        <= vec + VW'(1);
            dut_sw     <= vec + VW'(1);
            settle_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n_ripple_carry_adder_bist.sv
// Directed bench for n_ripple_carry_adder_bist (bits=2, SETTLE=2) driving a behavioural adder with injectable faults.
module tb_n_ripple_carry_adder_bist;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [4:0] dut_sw;
  logic [2:0] dut_ledr;
  logic       busy, done, pass;
  logic [5:0] err_count;
  logic [4:0] fail_vec;

  int fault = 0;            // 0 good, 1 ledr[0] stuck-at-0, 2 co stuck-at-0
  int vectors = 0;
  int miscompares = 0;
  logic [2:0] sum;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  // First odd sum is vec 1; first carry is a=1,b=3,ci=0 -> vec 7.
  localparam int S0_ERR = 1,  S0_CYC = 6,  S0_SW = 1;
  localparam int CO_ERR = 1,  CO_CYC = 24, CO_SW = 7;
`else
  localparam int S0_ERR = 16, S0_CYC = 96, S0_SW = 31;
  localparam int CO_ERR = 16, CO_CYC = 96, CO_SW = 31;
`endif

  n_ripple_carry_adder_bist #(.bits(2), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .dut_sw(dut_sw), .dut_ledr(dut_ledr),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  always_comb begin
    sum      = {1'b0, dut_sw[3:2]} + {1'b0, dut_sw[1:0]} + {2'b00, dut_sw[4]};
    dut_ledr = sum;
    if (fault == 1) dut_ledr[0] = 1'b0;
    if (fault == 2) dut_ledr[2] = 1'b0;
  end

  // Pulses start and counts busy cycles until done; optionally re-pulses start at busy cycle 10.
  task automatic sweep(input bit poke10, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) cyc++;
      if (poke10 && cyc == 10) start = 1'b1;
    end
    if (to) begin
      vectors++; miscompares++;
      $display("FAIL sweep_timeout: done never rose, busy cycles %0d", cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1;   // start coincident with reset must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0 || pass !== 1'b0) begin miscompares++; $display("FAIL reset_done_pass: got %b%b want 00", done, pass); end
    vectors++; if (err_count !== 6'd0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", err_count); end
    vectors++; if (dut_sw !== 5'd0 || fail_vec !== 5'd0) begin miscompares++; $display("FAIL reset_sw_fv: got %0d/%0d want 0/0", dut_sw, fail_vec); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start: busy got %b want 0", busy); end
  endtask

  task automatic test_good_sweep;
    int  cyc;
    bit  to, seq_bad;
    fault = 0; cyc = 0; to = 1'b1; seq_bad = 1'b0;
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin to = 1'b0; break; end
      if (busy) begin
        cyc++;
        // each vector occupies 3 cycles: APPLY, APPLY, CHECK
        if (!seq_bad && dut_sw !== 5'((cyc - 1) / 3)) begin
          seq_bad = 1'b1;
          $display("FAIL good_sequence: cycle %0d dut_sw got %0d want %0d", cyc, dut_sw, (cyc - 1) / 3);
        end
      end
    end
    vectors++; if (seq_bad) miscompares++;
    vectors++; if (to || cyc != 96) begin miscompares++; $display("FAIL good_busy_cycles: got %0d want 96", cyc); end
    vectors++; if (pass !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL good_pass: pass/busy got %b/%b want 1/0", pass, busy); end
    vectors++; if (err_count !== 6'd0 || fail_vec !== 5'd0) begin miscompares++; $display("FAIL good_err_fv: got %0d/%0d want 0/0", err_count, fail_vec); end
    vectors++; if (dut_sw !== 5'd31) begin miscompares++; $display("FAIL good_last_sw: got %0d want 31", dut_sw); end
    repeat (5) @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_held: got %b want 1", done); end
  endtask

  task automatic test_stuck_s0;
    int cyc; bit to;
    fault = 1;
    sweep(1'b0, cyc, to);
    vectors++; if (cyc != S0_CYC) begin miscompares++; $display("FAIL s0_cycles: got %0d want %0d", cyc, S0_CYC); end
    vectors++; if (err_count !== 6'(S0_ERR)) begin miscompares++; $display("FAIL s0_err: got %0d want %0d", err_count, S0_ERR); end
    vectors++; if (fail_vec !== 5'b00001) begin miscompares++; $display("FAIL s0_fail_vec: got %b want 00001", fail_vec); end
    vectors++; if (pass !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL s0_pass: pass/done got %b/%b want 0/1", pass, done); end
    vectors++; if (dut_sw !== 5'(S0_SW)) begin miscompares++; $display("FAIL s0_sw: got %0d want %0d", dut_sw, S0_SW); end
  endtask

  task automatic test_restart_from_done;
    int cyc; bit to;
    fault = 0;
    sweep(1'b0, cyc, to);
    vectors++; if (cyc != 96) begin miscompares++; $display("FAIL restart_cycles: got %0d want 96", cyc); end
    vectors++; if (err_count !== 6'd0 || fail_vec !== 5'd0) begin miscompares++; $display("FAIL restart_cleared: got %0d/%0d want 0/0", err_count, fail_vec); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL restart_pass: got %b want 1", pass); end
  endtask

  task automatic test_reset_mid_sweep;
    int cyc; bit to;
    fault = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_done: got %b%b want 00", busy, done); end
    vectors++; if (dut_sw !== 5'd0) begin miscompares++; $display("FAIL midrst_sw: got %0d want 0", dut_sw); end
    vectors++; if (err_count !== 6'd0 || fail_vec !== 5'd0) begin miscompares++; $display("FAIL midrst_err_fv: got %0d/%0d want 0/0", err_count, fail_vec); end
    reset = 1'b0;
    fault = 0;
    sweep(1'b0, cyc, to);
    vectors++; if (cyc != 96 || pass !== 1'b1) begin miscompares++; $display("FAIL midrst_resweep: cycles %0d pass %b want 96 1", cyc, pass); end
  endtask

  task automatic test_start_while_busy;
    int cyc; bit to;
    fault = 0;
    sweep(1'b1, cyc, to);
    vectors++; if (cyc != 96) begin miscompares++; $display("FAIL busy_start_cycles: got %0d want 96", cyc); end
    vectors++; if (pass !== 1'b1 || dut_sw !== 5'd31) begin miscompares++; $display("FAIL busy_start_result: pass %b sw %0d want 1 31", pass, dut_sw); end
  endtask

  task automatic test_co_stuck;
    int cyc; bit to;
    fault = 2;
    sweep(1'b0, cyc, to);
    vectors++; if (cyc != CO_CYC) begin miscompares++; $display("FAIL co_cycles: got %0d want %0d", cyc, CO_CYC); end
    vectors++; if (err_count !== 6'(CO_ERR)) begin miscompares++; $display("FAIL co_err: got %0d want %0d", err_count, CO_ERR); end
    vectors++; if (fail_vec !== 5'b00111) begin miscompares++; $display("FAIL co_fail_vec: got %b want 00111", fail_vec); end
    vectors++; if (dut_sw !== 5'(CO_SW) || pass !== 1'b0) begin miscompares++; $display("FAIL co_sw_pass: sw %0d pass %b want %0d 0", dut_sw, pass, CO_SW); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    test_reset;
    test_good_sweep;
    test_stuck_s0;
    test_restart_from_done;
    test_reset_mid_sweep;
    test_start_while_busy;
    test_co_stuck;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
